// File: rtl/aes_pkg.sv
// Shared AES definitions: round FSM states, datapath widths, GF(2^8) helpers
// and the ShiftRows byte permutation.
package aes_pkg;

    localparam int unsigned StateW  = 128;
    localparam int unsigned WordW   = 32;
    localparam int unsigned ByteW   = 8;
    localparam int unsigned NumCols = 4;

    // Reduction constant for x^8 = x^4 + x^3 + x + 1 (polynomial 0x11B)
    localparam logic [ByteW-1:0] XtimePoly = 8'h1B;

    typedef enum logic [1:0] {
        StIdle,
        StMix,
        StHold
    } round_st_e;

    // Source byte index for output byte k after ShiftRows (row r rotated left by r)
    function automatic int unsigned shift_rows_src(input int unsigned k);
        int unsigned c;
        int unsigned r;
        c = k / 4;
        r = k % 4;
        return 4 * ((c + r) % 4) + r;
    endfunction

    function automatic logic [ByteW-1:0] xtime(input logic [ByteW-1:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? XtimePoly : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mixcolumns.sv
// Single-column AES MixColumns: purely combinational 32-bit column mixer.
module aes_mixcolumns
    import aes_pkg::*;
(
    input  logic [WordW-1:0] col_in,
    output logic [WordW-1:0] col_out
);

    logic [ByteW-1:0] a0, a1, a2, a3;
    logic [ByteW-1:0] x0, x1, x2, x3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3a = 2a ^ a
    always_comb begin
        col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
    end

endmodule

// File: rtl/aes_round_mix.sv
// Back half of an AES-128 round: ShiftRows, MixColumns, AddRoundKey.
// Default build mixes one column per cycle through a shared mixer.
// Define AES_ROUND_MIX_PARALLEL_EN to mix all four columns in one cycle.
module aes_round_mix
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [StateW-1:0] state_in,
    input  logic [StateW-1:0] key_in,
    input  logic              last_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [StateW-1:0] state_out
);

    round_st_e         fsm_q, fsm_d;
    logic [StateW-1:0] data_q, data_d;
    logic [StateW-1:0] key_q, key_d;
    logic              last_q, last_d;
    logic [StateW-1:0] shifted;

    // ShiftRows on the incoming state
    always_comb begin
        shifted = '0;
        for (int k = 0; k < 16; k++) begin
            shifted[StateW-1-ByteW*k -: ByteW] =
                state_in[StateW-1-ByteW*int'(shift_rows_src(k)) -: ByteW];
        end
    end

`ifdef AES_ROUND_MIX_PARALLEL_EN
    logic [StateW-1:0] mix_all;

    for (genvar g = 0; g < NumCols; g++) begin : g_mix
        aes_mixcolumns u_mix (
            .col_in  (data_q[StateW-1-WordW*g -: WordW]),
            .col_out (mix_all[StateW-1-WordW*g -: WordW])
        );
    end
`else
    logic [1:0]       col_q, col_d;
    logic [WordW-1:0] mix_in;
    logic [WordW-1:0] mix_out;
    logic [WordW-1:0] key_word;

    // Select the column currently being mixed and its key word
    always_comb begin
        mix_in   = '0;
        key_word = '0;
        for (int c = 0; c < NumCols; c++) begin
            if (col_q == 2'(c)) begin
                mix_in   = data_q[StateW-1-WordW*c -: WordW];
                key_word = key_q[StateW-1-WordW*c -: WordW];
            end
        end
    end

    aes_mixcolumns u_mix (
        .col_in  (mix_in),
        .col_out (mix_out)
    );
`endif

    // Next-state logic for the round FSM and datapath registers
    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        key_d  = key_q;
        last_d = last_q;
`ifndef AES_ROUND_MIX_PARALLEL_EN
        col_d  = col_q;
`endif
        unique case (fsm_q)
            StIdle: begin
                if (in_valid) begin
                    key_d  = key_in;
                    last_d = last_round;
`ifndef AES_ROUND_MIX_PARALLEL_EN
                    col_d  = 2'd0;
`endif
                    if (last_round) begin
                        data_d = shifted ^ key_in;
                        fsm_d  = StHold;
                    end else begin
                        data_d = shifted;
                        fsm_d  = StMix;
                    end
                end
            end
            StMix: begin
`ifdef AES_ROUND_MIX_PARALLEL_EN
                data_d = mix_all ^ key_q;
                fsm_d  = StHold;
`else
                for (int c = 0; c < NumCols; c++) begin
                    if (col_q == 2'(c)) begin
                        data_d[StateW-1-WordW*c -: WordW] = mix_out ^ key_word;
                    end
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = StHold;
                end
`endif
            end
            StHold: begin
                if (out_ready) begin
                    fsm_d = StIdle;
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= StIdle;
            data_q <= '0;
            key_q  <= '0;
            last_q <= 1'b0;
`ifndef AES_ROUND_MIX_PARALLEL_EN
            col_q  <= 2'd0;
`endif
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            key_q  <= key_d;
            last_q <= last_d;
`ifndef AES_ROUND_MIX_PARALLEL_EN
            col_q  <= col_d;
`endif
        end
    end

    // last_q is kept for observability of the captured round type
    logic unused_last;
    assign unused_last = last_q;

    assign in_ready  = (fsm_q == StIdle);
    assign out_valid = (fsm_q == StHold);
    assign state_out = data_q;

endmodule

// File: tb/tb_aes_round_mix.sv
// Self-checking bench for aes_round_mix against a byte-matrix AES reference.
module tb_aes_round_mix;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    int n_checks = 0;
    int n_errors = 0;

`ifdef AES_ROUND_MIX_PARALLEL_EN
    localparam int NormLat = 2;
    localparam int NormGap = 3;
`else
    localparam int NormLat = 5;
    localparam int NormGap = 6;
`endif

    always #5 clk = ~clk;

    aes_round_mix dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .state_in   (state_in),
        .key_in     (key_in),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .state_out  (state_out)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply, shift-and-add with reduction by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Reference round on a 4x4 byte matrix s[row][col]
    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] m [4][4];
        logic [7:0] base [4];
        logic [127:0] res;
        base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = st[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = s[r][(c+r)%4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                m[r][c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    m[r][c] = m[r][c] ^ gmul(base[(j-r+4)%4], t[j][c]);
                if (last) m[r][c] = t[r][c];
            end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = m[r][c];
        return res ^ key;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One transaction from IDLE: returns result and accept-to-valid latency in edges
    task automatic run_round(input logic [127:0] st, input logic [127:0] key, input logic last,
                             output logic [127:0] got, output int lat);
        state_in   = st;
        key_in     = key;
        last_round = last;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        state_in   = rand128();
        key_in     = rand128();
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = state_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [127:0] st, ky, got, held;
    logic [127:0] exp_q [3];
    int lat;
    int acc_cyc [3];
    int out_cyc [3];

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        state_in   = '0;
        key_in     = '0;
        last_round = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_in_ready", 128'(in_ready), 128'd1);
        check_eq("reset_out_valid", 128'(out_valid), 128'd0);
        check_eq("reset_state_out", state_out, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single column: column 0 after ShiftRows = db135345
        st = '0;
        st[127:120] = 8'hdb;
        st[87:80]   = 8'h13;
        st[47:40]   = 8'h53;
        st[7:0]     = 8'h45;
        run_round(st, 128'd0, 1'b0, got, lat);
        check_eq("single_col", 128'(got[127:96]), 128'h8e4da1bc);
        check_eq("single_col_full", got, ref_round(st, 128'd0, 1'b0));

        // FIPS-197 App. B round 1
        st = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
        ky = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        run_round(st, ky, 1'b0, got, lat);
        check_eq("fips_round1", got, 128'ha49c7ff2_689f352b_6b5bea43_026a5049);
        check_eq("fips_latency", 128'(lat), 128'(NormLat));
        check_eq("ready_after_hold", 128'(in_ready), 128'd1);

        // Final round: MixColumns skipped
        run_round(st, ky, 1'b1, got, lat);
        check_eq("last_round", got, ref_round(st, ky, 1'b1));
        check_eq("last_round_col0", 128'(got[127:96]), 128'(32'h74_45_a3_27));
        check_eq("last_latency", 128'(lat), 128'd1);

        // Backpressure: hold output for 10 cycles, in_valid pulses ignored
        st = rand128();
        ky = rand128();
        state_in = st; key_in = ky; last_round = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_latency", 128'(lat), 128'(NormLat));
        held = state_out;
        check_eq("bp_result", held, ref_round(st, ky, 1'b0));
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            state_in = rand128();
            key_in   = rand128();
            @(posedge clk); #1;
            check_eq("bp_stable", state_out, held);
            check_eq("bp_in_ready", 128'(in_ready), 128'd0);
            check_eq("bp_out_valid", 128'(out_valid), 128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_release_out_valid", 128'(out_valid), 128'd0);
        check_eq("bp_release_in_ready", 128'(in_ready), 128'd1);
        st = rand128();
        ky = rand128();
        run_round(st, ky, 1'b0, got, lat);
        check_eq("bp_next", got, ref_round(st, ky, 1'b0));

        // Reset in the middle of MIX
        state_in = rand128(); key_in = rand128(); last_round = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", 128'(in_ready), 128'd1);
        check_eq("midrst_out_valid", 128'(out_valid), 128'd0);
        check_eq("midrst_state_out", state_out, 128'd0);
        @(posedge clk); #1;
        check_eq("midrst_hold_valid", 128'(out_valid), 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        st = rand128();
        ky = rand128();
        run_round(st, ky, 1'b0, got, lat);
        check_eq("post_rst_round", got, ref_round(st, ky, 1'b0));
        check_eq("post_rst_latency", 128'(lat), 128'(NormLat));

        // Back-to-back with in_valid and out_ready held high
        begin
            logic [127:0] sts [3];
            logic [127:0] kys [3];
            int idx;
            int n_out;
            int cyc;
            logic acc;
            for (int i = 0; i < 3; i++) begin
                sts[i]   = rand128();
                kys[i]   = rand128();
                exp_q[i] = ref_round(sts[i], kys[i], 1'b0);
            end
            idx = 0; n_out = 0; cyc = 0;
            state_in = sts[0]; key_in = kys[0]; last_round = 1'b0;
            in_valid = 1'b1; out_ready = 1'b1;
            while (n_out < 3 && cyc < 200) begin
                if (in_ready && out_valid) check_eq("b2b_exclusive", 128'd1, 128'd0);
                if (out_valid) begin
                    check_eq("b2b_result", state_out, exp_q[n_out]);
                    out_cyc[n_out] = cyc;
                    n_out++;
                end
                acc = in_ready && (idx < 3);
                if (acc) acc_cyc[idx] = cyc;
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    idx++;
                    if (idx < 3) begin
                        state_in = sts[idx];
                        key_in   = kys[idx];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            out_ready = 1'b0;
            in_valid  = 1'b0;
            check_eq("b2b_count", 128'(n_out), 128'd3);
            if (n_out == 3) begin
                check_eq("b2b_acc_gap0", 128'(acc_cyc[1] - acc_cyc[0]), 128'(NormGap));
                check_eq("b2b_acc_gap1", 128'(acc_cyc[2] - acc_cyc[1]), 128'(NormGap));
                check_eq("b2b_out_gap", 128'(out_cyc[2] - out_cyc[1]), 128'(NormGap));
                check_eq("b2b_lat", 128'(out_cyc[0] - acc_cyc[0]), 128'(NormLat));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
